i2s_voice_scheduler: RTL and testbench
======================================

I2S_VOICE_SCHEDULER -- requirements
Module: i2s_voice_scheduler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, max cycles voice_req_out stays high awaiting ack (legal 1..240).
REQ-002 clk_in  input  1  sole clock, all state on rising edge.
REQ-003 reset_n_in  input  1  asynchronous, active-low reset.
REQ-004 voice_enable_in  input  4  per-voice enable; bit i = voice i.
REQ-005 voice_ack_in  input  1  shared voice datapath has valid voice_data_in this cycle.
REQ-006 voice_data_in  input  16  signed two's-complement voice sample.
REQ-007 master_count_out  output  10  free-running frame counter, 1024 clocks per sample frame.
REQ-008 voice_req_out  output  1  request to shared voice datapath.
REQ-009 voice_sel_out  output  2  index of requested voice.
REQ-010 data_out  output  16  mixed signed sample for the I2S serializer.
REQ-011 data_valid_out  output  1  one-cycle strobe, data_out new.
REQ-012 timeout_out  output  1  sticky error flag.

Function
REQ-013 master_count_out increments by 1 every clock, wraps 1023 -> 0.
REQ-014 Frame start = any cycle with master_count_out == 0, including the first cycle after reset release.
REQ-015 States: IDLE, SCAN, REQ, OUT; all outputs registered.
REQ-016 IDLE: on frame start latch voice_enable_in, clear 18-bit signed accumulator, idx = 0, next state SCAN; else stay.
REQ-017 voice_enable_in changes after the latch cycle have no effect until the next frame start.
REQ-018 SCAN (one cycle per voice): latched bit idx set -> REQ; else idx == 3 -> OUT; else idx + 1, stay SCAN.
REQ-019 REQ: voice_req_out = 1, voice_sel_out = idx, both held stable until handshake or timeout.
REQ-020 Handshake = voice_req_out & voice_ack_in same cycle; accumulator += sign-extended voice_data_in.
REQ-021 After handshake or timeout: idx == 3 -> OUT, else idx + 1 -> SCAN; voice_req_out low the following cycle.
REQ-022 voice_ack_in while voice_req_out low is ignored.
REQ-023 Timeout: no ack within TIMEOUT_CYCLES cycles of REQ entry -> voice contributes 0, timeout_out set to 1 and held until reset, sequencing continues.
REQ-024 OUT: data_out = accumulator saturated to [-32768, 32767]; data_valid_out = 1 for exactly this cycle; next state IDLE.
REQ-025 data_out holds its value between OUT cycles; data_valid_out low in every non-OUT cycle.
REQ-026 Frame start while not in IDLE (overrun): abort current frame, no data_valid_out pulse, set timeout_out, restart sequence as in REQ-016.
REQ-027 voice_sel_out = 0 whenever voice_req_out is low.

Reset
REQ-028 reset_n_in low asynchronously forces: master_count_out 0, state IDLE, voice_req_out 0, voice_sel_out 0, data_out 0, data_valid_out 0, timeout_out 0, accumulator 0.
REQ-029 Reset asserted mid-frame (any state) discards the frame; no data_valid_out pulse.
REQ-030 After release the first frame start occurs on the first clock edge with master_count_out == 0.

Verification
REQ-031 Enables 4'b0000 -> data_valid_out high only while master_count_out == 5, data_out 0x0000, voice_req_out never high.
REQ-032 Enables 4'b0001, ack tied high, voice_data_in 0x1234 -> voice_req_out high 1 cycle at count 2 with sel 0, data_valid_out at count 6, data_out 0x1234.
REQ-033 Enables 4'b1111, ack tied high, data 0x7000 each -> data_out 0x7FFF; data 0x8000 each -> data_out 0x8000; data 0x0100,0xFF00,0x0010,0x0001 -> data_out 0x0011.
REQ-034 Enables 4'b0100, ack never high -> voice_req_out high exactly 64 cycles with sel 2, then timeout_out 1, data_out 0x0000, data_valid_out still pulses once.
REQ-035 reset_n_in low during REQ -> voice_req_out, master_count_out, data_out 0 without waiting for a clock edge; no strobe that frame; normal frame after release.
REQ-036 Enables toggled 4'b0001 -> 4'b1111 at count 3 -> only voice 0 requested this frame, all four requested next frame.

Source files
------------

// File: rtl/i2s_voice_scheduler.sv
// rtl/i2s_voice_scheduler.sv - per-frame scheduler that fetches up to four voices
// from a shared datapath and mixes them into one saturated sample for I2S.
module i2s_voice_scheduler #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk_in,
   input  logic        reset_n_in,
   input  logic [3:0]  voice_enable_in,
   input  logic        voice_ack_in,
   input  logic [15:0] voice_data_in,
   output logic [9:0]  master_count_out,
   output logic        voice_req_out,
   output logic [1:0]  voice_sel_out,
   output logic [15:0] data_out,
   output logic        data_valid_out,
   output logic        timeout_out
);

   typedef enum logic [1:0] {IDLE, SCAN, REQ, OUT} state_t;

   state_t             state;
   logic [3:0]         en_lat;
   logic [1:0]         idx;
   logic [7:0]         wait_cnt;
   logic signed [17:0] acc;
   logic signed [17:0] acc_sum;
   logic signed [17:0] sample_ext;
   logic               handshake;
   logic               frame_start;
   logic               wait_expired;

   assign frame_start  = (master_count_out == 10'd0);
   assign handshake    = voice_req_out & voice_ack_in;
   assign wait_expired = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
   assign sample_ext   = {{2{voice_data_in[15]}}, voice_data_in};
   // Folding the current sample in here lets the last voice's handshake feed OUT directly.
   assign acc_sum      = handshake ? (acc + sample_ext) : acc;

   function automatic logic [15:0] sat16(input logic signed [17:0] v);
      if (v > 18'sd32767)
         sat16 = 16'h7FFF;
      else if (v < -18'sd32768)
         sat16 = 16'h8000;
      else
         sat16 = v[15:0];
   endfunction

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         master_count_out <= 10'd0;
         state            <= IDLE;
         en_lat           <= 4'd0;
         idx              <= 2'd0;
         wait_cnt         <= 8'd0;
         acc              <= 18'sd0;
         voice_req_out    <= 1'b0;
         voice_sel_out    <= 2'd0;
         data_out         <= 16'd0;
         data_valid_out   <= 1'b0;
         timeout_out      <= 1'b0;
      end else begin
         master_count_out <= master_count_out + 10'd1;
         data_valid_out   <= 1'b0;
         if (frame_start) begin
            // A frame still in flight at frame start is an overrun: drop it and flag it.
            if (state != IDLE)
               timeout_out <= 1'b1;
            en_lat        <= voice_enable_in;
            acc           <= 18'sd0;
            idx           <= 2'd0;
            wait_cnt      <= 8'd0;
            voice_req_out <= 1'b0;
            voice_sel_out <= 2'd0;
            state         <= SCAN;
         end else begin
            case (state)
               IDLE: state <= IDLE;
               SCAN: begin
                  if (en_lat[idx]) begin
                     state         <= REQ;
                     voice_req_out <= 1'b1;
                     voice_sel_out <= idx;
                     wait_cnt      <= 8'd0;
                  end else if (idx == 2'd3) begin
                     state          <= OUT;
                     data_out       <= sat16(acc);
                     data_valid_out <= 1'b1;
                  end else begin
                     idx <= idx + 2'd1;
                  end
               end
               REQ: begin
                  if (handshake || wait_expired) begin
                     acc           <= acc_sum;
                     voice_req_out <= 1'b0;
                     voice_sel_out <= 2'd0;
                     if (!handshake)
                        timeout_out <= 1'b1;
                     if (idx == 2'd3) begin
                        state          <= OUT;
                        data_out       <= sat16(acc_sum);
                        data_valid_out <= 1'b1;
                     end else begin
                        idx   <= idx + 2'd1;
                        state <= SCAN;
                     end
                  end else begin
                     wait_cnt <= wait_cnt + 8'd1;
                  end
               end
               OUT: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2s_voice_scheduler.sv
// tb/tb_i2s_voice_scheduler.sv - scoreboard bench for i2s_voice_scheduler.
module tb_i2s_voice_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  en = 4'd0;
   logic        ack = 1'b0;
   logic [15:0] vdata;
   logic [9:0]  count;
   logic        req;
   logic [1:0]  sel;
   logic [15:0] dout;
   logic        dvalid;
   logic        tout;

   logic [15:0] data_tab [4];

   i2s_voice_scheduler #(.TIMEOUT_CYCLES(64)) dut (
      .clk_in           (clk),
      .reset_n_in       (rst_n),
      .voice_enable_in  (en),
      .voice_ack_in     (ack),
      .voice_data_in    (vdata),
      .master_count_out (count),
      .voice_req_out    (req),
      .voice_sel_out    (sel),
      .data_out         (dout),
      .data_valid_out   (dvalid),
      .timeout_out      (tout)
   );

   always #5 clk = ~clk;

   // Shared datapath model: presents the sample of whichever voice is selected.
   assign vdata = data_tab[sel];

   typedef struct {
      int          cnt;
      logic [15:0] val;
   } out_t;
   typedef struct {
      int cnt;
      int sel;
      int len;
   } req_t;

   out_t out_q[$];
   req_t req_q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_out(input int c, input logic [15:0] v);
      out_t o;
      o.cnt = c;
      o.val = v;
      out_q.push_back(o);
   endtask

   task automatic push_req(input int c, input int s, input int l);
      req_t r;
      r.cnt = c;
      r.sel = s;
      r.len = l;
      req_q.push_back(r);
   endtask

   task automatic push_all4();
      push_req(2, 0, 1);
      push_req(4, 1, 1);
      push_req(6, 2, 1);
      push_req(8, 3, 1);
   endtask

   task automatic wait_cnt(input int target);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 4096 && !hit; i++) begin
         @(negedge clk);
         if (count == 10'(target))
            hit = 1'b1;
      end
      if (!hit)
         check("wait_cnt_bound", 32'd0, 32'd1);
   endtask

   // Monitor: pops expectations whenever the DUT strobes or raises a request.
   bit in_burst = 1'b0;
   int burst_len = 0;
   int exp_len = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_burst = 1'b0;
      end else begin
         if (dvalid) begin
            if (out_q.size() == 0) begin
               check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
               out_t o;
               o = out_q.pop_front();
               check("strobe_count", 32'(count), 32'(o.cnt));
               check("data_out", 32'(dout), 32'(o.val));
            end
         end
         if (req && !in_burst) begin
            in_burst = 1'b1;
            burst_len = 1;
            if (req_q.size() == 0) begin
               check("unexpected_req", 32'd1, 32'd0);
               exp_len = 0;
            end else begin
               req_t r;
               r = req_q.pop_front();
               check("req_start", 32'(count), 32'(r.cnt));
               check("req_sel", 32'(sel), 32'(r.sel));
               exp_len = r.len;
            end
         end else if (req && in_burst) begin
            burst_len++;
         end else if (!req && in_burst) begin
            in_burst = 1'b0;
            check("req_len", 32'(burst_len), 32'(exp_len));
            check("sel_idle", 32'(sel), 32'd0);
         end
      end
   end

   initial begin
      for (int i = 0; i < 4; i++) data_tab[i] = 16'h0000;

      repeat (2) @(negedge clk);
      check("rst_count", 32'(count), 32'd0);
      check("rst_req", 32'(req), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_data", 32'(dout), 32'd0);
      check("rst_valid", 32'(dvalid), 32'd0);
      check("rst_timeout", 32'(tout), 32'd0);

      // No voices: strobe at count 5 with zero.
      en = 4'b0000;
      push_out(5, 16'h0000);
      rst_n = 1'b1;

      // Single voice, ack tied high.
      wait_cnt(1000);
      en = 4'b0001;
      ack = 1'b1;
      data_tab[0] = 16'h1234;
      push_req(2, 0, 1);
      push_out(6, 16'h1234);

      // Positive saturation.
      wait_cnt(1000);
      en = 4'b1111;
      for (int i = 0; i < 4; i++) data_tab[i] = 16'h7000;
      push_all4();
      push_out(9, 16'h7FFF);

      // Negative saturation.
      wait_cnt(1000);
      for (int i = 0; i < 4; i++) data_tab[i] = 16'h8000;
      push_all4();
      push_out(9, 16'h8000);

      // Mixed signs.
      wait_cnt(1000);
      data_tab[0] = 16'h0100;
      data_tab[1] = 16'hFF00;
      data_tab[2] = 16'h0010;
      data_tab[3] = 16'h0001;
      push_all4();
      push_out(9, 16'h0011);

      // Enable change after the latch cycle applies only from the next frame.
      wait_cnt(1000);
      en = 4'b0001;
      push_req(2, 0, 1);
      push_out(6, 16'h0100);
      wait_cnt(3);
      en = 4'b1111;
      wait_cnt(1000);
      push_all4();
      push_out(9, 16'h0011);

      // Reset while waiting in REQ.
      wait_cnt(1000);
      en = 4'b0100;
      ack = 1'b0;
      push_req(4, 2, 64);
      wait_cnt(10);
      check("req_before_reset", 32'(req), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("async_req", 32'(req), 32'd0);
      check("async_count", 32'(count), 32'd0);
      check("async_data", 32'(dout), 32'd0);
      check("async_sel", 32'(sel), 32'd0);
      en = 4'b0001;
      ack = 1'b1;
      data_tab[0] = 16'h1234;
      repeat (2) @(negedge clk);
      push_req(2, 0, 1);
      push_out(6, 16'h1234);
      rst_n = 1'b1;
      wait_cnt(100);
      check("timeout_clear", 32'(tout), 32'd0);

      // Timeout: voice 2 never acked.
      wait_cnt(1000);
      en = 4'b0100;
      ack = 1'b0;
      push_req(4, 2, 64);
      push_out(69, 16'h0000);
      wait_cnt(67);
      check("timeout_pre", 32'(tout), 32'd0);
      wait_cnt(68);
      check("timeout_set", 32'(tout), 32'd1);
      wait_cnt(200);
      check("timeout_held", 32'(tout), 32'd1);

      check("out_q_empty", 32'(out_q.size()), 32'd0);
      check("req_q_empty", 32'(req_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
